// File: rtl/flag_ctrl.sv
// flag_ctrl: processor status flag {Z,N,C,V} write controller.
// Merges masked ALU and mul/div flag updates with a one-entry pending buffer,
// saves/restores flags through an interrupt LIFO, and evaluates branch conditions.
module flag_ctrl #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alu_valid,
    input  logic [3:0]                         alu_flags,
    input  logic [3:0]                         alu_mask,
    output logic                               alu_ready,
    input  logic                               mul_valid,
    input  logic [3:0]                         mul_flags,
    input  logic [3:0]                         mul_mask,
    output logic                               mul_ready,
    input  logic                               irq_save,
    input  logic                               irq_restore,
    input  logic [3:0]                         cond,
    output logic [3:0]                         flags_out,
    output logic                               cond_true,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_depth,
    output logic                               stk_err
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Pending mul/div update deferred by a competing writer
    logic          pend_valid;
    logic [3:0]    pend_flags;
    logic [3:0]    pend_mask;
    logic [1:0]    pend_age;

    logic          pend_valid_nxt;
    logic [3:0]    pend_flags_nxt;
    logic [3:0]    pend_mask_nxt;
    logic [1:0]    pend_age_nxt;
    logic [3:0]    flags_nxt;
    logic [DW-1:0] depth_nxt;
    logic          err_nxt;

    logic [3:0]    lifo [STACK_DEPTH];
    logic [3:0]    lifo_top;
    logic          mul_hs;
    logic          forced_drain;
    logic          save_ok;
    logic          restore_ok;
    logic          stk_full;
    logic          stk_empty;

    assign stk_full     = (stk_depth == DW'(STACK_DEPTH));
    assign stk_empty    = (stk_depth == '0);
    assign save_ok      = irq_save && !irq_restore && !stk_full;
    assign restore_ok   = irq_restore && !irq_save && !stk_empty;
    assign forced_drain = pend_valid && (pend_age == 2'd2);
    assign alu_ready    = !forced_drain;
    assign mul_ready    = !pend_valid;
    assign mul_hs       = mul_valid && mul_ready;
    assign lifo_top     = stk_empty ? 4'b0000 : lifo[AW'(stk_depth - DW'(1))];

    // Next-state: write-source arbitration, pending buffer, LIFO depth, error pulse
    always_comb begin
        flags_nxt      = flags_out;
        pend_valid_nxt = pend_valid;
        pend_flags_nxt = pend_flags;
        pend_mask_nxt  = pend_mask;
        pend_age_nxt   = pend_age;
        depth_nxt      = stk_depth;
        err_nxt        = 1'b0;

        if (restore_ok) begin
            flags_nxt = lifo_top;
        end else if (forced_drain) begin
            flags_nxt = (flags_out & ~pend_mask) | (pend_flags & pend_mask);
        end else if (alu_valid) begin
            flags_nxt = (flags_out & ~alu_mask) | (alu_flags & alu_mask);
        end else if (pend_valid) begin
            flags_nxt = (flags_out & ~pend_mask) | (pend_flags & pend_mask);
        end else if (mul_hs) begin
            flags_nxt = (flags_out & ~mul_mask) | (mul_flags & mul_mask);
        end

        if (pend_valid) begin
            pend_age_nxt = (pend_age == 2'd2) ? 2'd2 : pend_age + 2'd1;
            if (!restore_ok && (forced_drain || !alu_valid)) begin
                pend_valid_nxt = 1'b0;
            end
        end

        // Handshake while another source owns the write slot is deferred
        if (mul_hs && (restore_ok || alu_valid)) begin
            pend_valid_nxt = 1'b1;
            pend_flags_nxt = mul_flags;
            pend_mask_nxt  = mul_mask;
            pend_age_nxt   = 2'd0;
        end

        if (save_ok) begin
            depth_nxt = stk_depth + DW'(1);
        end else if (restore_ok) begin
            depth_nxt = stk_depth - DW'(1);
        end

        if (irq_save && irq_restore) begin
            err_nxt = 1'b1;
        end else if (irq_save && stk_full) begin
            err_nxt = 1'b1;
        end else if (irq_restore && stk_empty) begin
            err_nxt = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_out  <= 4'b0000;
            pend_valid <= 1'b0;
            pend_flags <= 4'b0000;
            pend_mask  <= 4'b0000;
            pend_age   <= 2'd0;
            stk_depth  <= '0;
            stk_err    <= 1'b0;
        end else begin
            flags_out  <= flags_nxt;
            pend_valid <= pend_valid_nxt;
            pend_flags <= pend_flags_nxt;
            pend_mask  <= pend_mask_nxt;
            pend_age   <= pend_age_nxt;
            stk_depth  <= depth_nxt;
            stk_err    <= err_nxt;
        end
    end

    // LIFO storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!reset && save_ok) begin
            lifo[AW'(stk_depth)] <= flags_out;
        end
    end

    // Branch condition evaluation against registered flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = flags_out[3];
            4'd1:  cond_true = !flags_out[3];
            4'd2:  cond_true = flags_out[1];
            4'd3:  cond_true = !flags_out[1];
            4'd4:  cond_true = flags_out[2];
            4'd5:  cond_true = !flags_out[2];
            4'd6:  cond_true = flags_out[0];
            4'd7:  cond_true = !flags_out[0];
            4'd8:  cond_true = flags_out[1] && !flags_out[3];
            4'd9:  cond_true = !flags_out[1] || flags_out[3];
            4'd10: cond_true = (flags_out[2] == flags_out[0]);
            4'd11: cond_true = (flags_out[2] != flags_out[0]);
            4'd12: cond_true = !flags_out[3] && (flags_out[2] == flags_out[0]);
            4'd13: cond_true = flags_out[3] || (flags_out[2] != flags_out[0]);
            4'd14: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
